// File: rtl/v_alu_issue_ctrl.sv
// Issue controller for the lane vector ALU: accepts one instruction, streams operand
// beats to the VRF, tracks ALU latency and hands masked result beats to writeback.
module v_alu_issue_ctrl #(
   parameter int PARALLEL_IF_NUM = 4,
   parameter int VL_W            = 12,
   parameter int ADDR_W          = 9,
   parameter int ALU_LAT         = 3,
   parameter int MUL32_LAT       = 5
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           instr_valid_i,
   output logic                           instr_ready_o,
   input  logic [6:0]                     instr_opmode_i,
   input  logic [VL_W-1:0]                instr_vl_i,
   input  logic                           instr_mul32_i,
   output logic                           vrf_ren_o,
   output logic [ADDR_W-1:0]              vrf_raddr_o,
   output logic [PARALLEL_IF_NUM*7-1:0]   alu_opmode_o,
   output logic                           alu_en_32bit_mul_o,
   output logic                           alu_stall_o,
   output logic                           wb_valid_o,
   output logic [ADDR_W-1:0]              wb_addr_o,
   output logic [PARALLEL_IF_NUM-1:0]     wb_lane_en_o,
   input  logic                           wb_ready_i,
   output logic                           busy_o,
   output logic                           done_o
);

   localparam int P     = PARALLEL_IF_NUM;
   localparam int TAP_N = ALU_LAT - 1;
   localparam int TAP_M = MUL32_LAT - 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [6:0]        opmode_q;
   logic              mul32_q;
   logic [ADDR_W-1:0] last_addr_q;
   logic [P-1:0]      last_mask_q;
   logic [ADDR_W-1:0] issue_cnt_q;

   logic              trk_vld_q  [MUL32_LAT];
   logic [ADDR_W-1:0] trk_addr_q [MUL32_LAT];
   logic [P-1:0]      trk_mask_q [MUL32_LAT];

   logic              accept;
   logic              stall;
   logic              issue_fire;
   logic              last_issue;
   logic              wb_fire;
   logic              last_wb;
   logic [P-1:0]      issue_mask;

   logic [VL_W:0]     vl_ext;
   logic [VL_W:0]     beats_norm;
   logic [VL_W:0]     beats_w;
   logic [ADDR_W-1:0] last_addr_w;
   logic [VL_W-1:0]   vl_rem;
   logic [P-1:0]      last_mask_w;

   // Beat geometry of the offered instruction, captured on accept.
   assign vl_ext      = {1'b0, instr_vl_i};
   assign beats_norm  = (vl_ext + (VL_W+1)'(P - 1)) / (VL_W+1)'(P);
   assign beats_w     = instr_mul32_i ? vl_ext : beats_norm;
   assign last_addr_w = ADDR_W'(beats_w - (VL_W+1)'(1));
   assign vl_rem      = instr_vl_i % VL_W'(P);

   generate
      for (genvar gi = 0; gi < P; gi++) begin : g_last_mask
         assign last_mask_w[gi] = (vl_rem == '0) || (vl_rem > VL_W'(gi));
      end
   endgenerate

   assign accept     = instr_valid_i && (state_q == S_IDLE);
   assign stall      = wb_valid_o && !wb_ready_i;
   assign issue_fire = (state_q == S_ISSUE) && !stall;
   assign last_issue = issue_fire && (issue_cnt_q == last_addr_q);
   assign wb_fire    = wb_valid_o && wb_ready_i;
   assign last_wb    = wb_fire && (wb_addr_o == last_addr_q);

   always_comb begin
      issue_mask = '1;
      if (mul32_q) begin
         issue_mask = P'(1);
      end else if (issue_cnt_q == last_addr_q) begin
         issue_mask = last_mask_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = (instr_vl_i == '0) ? S_DONE : S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (last_issue) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (last_wb) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         opmode_q    <= '0;
         mul32_q     <= 1'b0;
         last_addr_q <= '0;
         last_mask_q <= '0;
         issue_cnt_q <= '0;
      end else if (accept) begin
         opmode_q    <= instr_opmode_i;
         mul32_q     <= instr_mul32_i;
         last_addr_q <= last_addr_w;
         last_mask_q <= last_mask_w;
         issue_cnt_q <= '0;
      end else if (issue_fire) begin
         issue_cnt_q <= issue_cnt_q + ADDR_W'(1);
      end
   end

   // Accept flushes the tracker so leftovers past the short tap never reach a
   // following long-latency instruction.
   always_ff @(posedge clk) begin
      if (rst) begin
         trk_vld_q[0]  <= 1'b0;
         trk_addr_q[0] <= '0;
         trk_mask_q[0] <= '0;
      end else if (accept) begin
         trk_vld_q[0]  <= 1'b0;
      end else if (!stall) begin
         trk_vld_q[0]  <= issue_fire;
         trk_addr_q[0] <= issue_cnt_q;
         trk_mask_q[0] <= issue_mask;
      end
   end

   generate
      for (genvar gi = 1; gi < MUL32_LAT; gi++) begin : g_trk
         always_ff @(posedge clk) begin
            if (rst) begin
               trk_vld_q[gi]  <= 1'b0;
               trk_addr_q[gi] <= '0;
               trk_mask_q[gi] <= '0;
            end else if (accept) begin
               trk_vld_q[gi]  <= 1'b0;
            end else if (!stall) begin
               trk_vld_q[gi]  <= trk_vld_q[gi-1];
               trk_addr_q[gi] <= trk_addr_q[gi-1];
               trk_mask_q[gi] <= trk_mask_q[gi-1];
            end
         end
      end
   endgenerate

   assign wb_valid_o   = mul32_q ? trk_vld_q[TAP_M]  : trk_vld_q[TAP_N];
   assign wb_addr_o    = mul32_q ? trk_addr_q[TAP_M] : trk_addr_q[TAP_N];
   assign wb_lane_en_o = mul32_q ? trk_mask_q[TAP_M] : trk_mask_q[TAP_N];

   generate
      for (genvar gi = 0; gi < P; gi++) begin : g_opmode
         assign alu_opmode_o[gi*7 +: 7] = opmode_q;
      end
   endgenerate

   assign instr_ready_o      = (state_q == S_IDLE);
   assign busy_o             = (state_q != S_IDLE);
   assign done_o             = (state_q == S_DONE);
   assign vrf_ren_o          = issue_fire;
   assign vrf_raddr_o        = issue_cnt_q;
   assign alu_en_32bit_mul_o = mul32_q;
   assign alu_stall_o        = stall;

endmodule

// File: tb/tb_v_alu_issue_ctrl.sv
// Directed bench for v_alu_issue_ctrl: per-cycle timelines relative to the accept cycle.
module tb_v_alu_issue_ctrl;

   logic        clk;
   logic        rst;
   logic        instr_valid_i;
   logic        instr_ready_o;
   logic [6:0]  instr_opmode_i;
   logic [11:0] instr_vl_i;
   logic        instr_mul32_i;
   logic        vrf_ren_o;
   logic [8:0]  vrf_raddr_o;
   logic [27:0] alu_opmode_o;
   logic        alu_en_32bit_mul_o;
   logic        alu_stall_o;
   logic        wb_valid_o;
   logic [8:0]  wb_addr_o;
   logic [3:0]  wb_lane_en_o;
   logic        wb_ready_i;
   logic        busy_o;
   logic        done_o;

   int pass_cnt  = 0;
   int total_cnt = 0;

   v_alu_issue_ctrl dut (
      .clk                (clk),
      .rst                (rst),
      .instr_valid_i      (instr_valid_i),
      .instr_ready_o      (instr_ready_o),
      .instr_opmode_i     (instr_opmode_i),
      .instr_vl_i         (instr_vl_i),
      .instr_mul32_i      (instr_mul32_i),
      .vrf_ren_o          (vrf_ren_o),
      .vrf_raddr_o        (vrf_raddr_o),
      .alu_opmode_o       (alu_opmode_o),
      .alu_en_32bit_mul_o (alu_en_32bit_mul_o),
      .alu_stall_o        (alu_stall_o),
      .wb_valid_o         (wb_valid_o),
      .wb_addr_o          (wb_addr_o),
      .wb_lane_en_o       (wb_lane_en_o),
      .wb_ready_i         (wb_ready_i),
      .busy_o             (busy_o),
      .done_o             (done_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offers one instruction for a single cycle; returns 1 ns after the accepting edge.
   task automatic send(input logic [6:0] op, input logic [11:0] vl, input logic m32);
      $display("instr: opmode=0x%02h vl=%0d mul32=%0d", op, vl, m32);
      instr_valid_i  = 1'b1;
      instr_opmode_i = op;
      instr_vl_i     = vl;
      instr_mul32_i  = m32;
      step();
      instr_valid_i  = 1'b0;
   endtask

   task automatic test_reset();
      logic [8:0] obs;
      obs = {instr_ready_o, busy_o, done_o, vrf_ren_o, wb_valid_o, alu_stall_o,
             alu_en_32bit_mul_o, (alu_opmode_o != '0), (vrf_raddr_o != '0)};
      total_cnt++;
      if (obs !== 9'b100000000) $display("FAIL reset_state got %b want %b", obs, 9'b100000000);
      else pass_cnt++;
   endtask

   task automatic test_basic();
      logic [3:0] obs, exp;
      send(7'h2A, 12'd8, 1'b0);
      for (int c = 1; c <= 8; c++) begin
         obs = {vrf_ren_o, wb_valid_o, done_o, alu_stall_o};
         exp = {(c <= 2), (c == 4 || c == 5), (c == 6), 1'b0};
         total_cnt++;
         if (obs !== exp) $display("FAIL basic_ctrl c=%0d got %b want %b", c, obs, exp);
         else pass_cnt++;
         if (exp[3]) begin
            total_cnt++;
            if (vrf_raddr_o !== 9'(c - 1)) $display("FAIL basic_raddr c=%0d got %0d want %0d", c, vrf_raddr_o, c - 1);
            else pass_cnt++;
         end
         if (exp[2]) begin
            total_cnt++;
            if ({wb_addr_o, wb_lane_en_o} !== {9'(c - 4), 4'b1111})
               $display("FAIL basic_wb c=%0d got addr=%0d mask=%b want addr=%0d mask=1111", c, wb_addr_o, wb_lane_en_o, c - 4);
            else pass_cnt++;
         end
         step();
      end
   endtask

   task automatic test_partial_mask();
      logic [2:0] obs, exp;
      logic [27:0] op_exp;
      op_exp = {4{7'h5B}};
      send(7'h5B, 12'd6, 1'b0);
      total_cnt++;
      if (alu_opmode_o !== op_exp) $display("FAIL partial_opmode got %h want %h", alu_opmode_o, op_exp);
      else pass_cnt++;
      for (int c = 1; c <= 7; c++) begin
         obs = {vrf_ren_o, wb_valid_o, done_o};
         exp = {(c <= 2), (c == 4 || c == 5), (c == 6)};
         total_cnt++;
         if (obs !== exp) $display("FAIL partial_ctrl c=%0d got %b want %b", c, obs, exp);
         else pass_cnt++;
         if (exp[1]) begin
            total_cnt++;
            if ({wb_addr_o, wb_lane_en_o} !== {9'(c - 4), (c == 4) ? 4'b1111 : 4'b0011})
               $display("FAIL partial_wb c=%0d got addr=%0d mask=%b", c, wb_addr_o, wb_lane_en_o);
            else pass_cnt++;
         end
         step();
      end
   endtask

   task automatic test_mul32();
      logic [3:0] obs, exp;
      send(7'h0C, 12'd3, 1'b1);
      for (int c = 1; c <= 10; c++) begin
         obs = {vrf_ren_o, wb_valid_o, done_o, alu_en_32bit_mul_o};
         exp = {(c <= 3), (c >= 6 && c <= 8), (c == 9), 1'b1};
         total_cnt++;
         if (obs !== exp) $display("FAIL mul32_ctrl c=%0d got %b want %b", c, obs, exp);
         else pass_cnt++;
         if (exp[2]) begin
            total_cnt++;
            if ({wb_addr_o, wb_lane_en_o} !== {9'(c - 6), 4'b0001})
               $display("FAIL mul32_wb c=%0d got addr=%0d mask=%b want addr=%0d mask=0001", c, wb_addr_o, wb_lane_en_o, c - 6);
            else pass_cnt++;
         end
         step();
      end
   endtask

   // Writeback refuses beat 1 for four cycles while issue still has beats left.
   task automatic test_stall();
      logic [3:0] obs, exp;
      int ea;
      send(7'h33, 12'd32, 1'b0);
      for (int c = 1; c <= 17; c++) begin
         wb_ready_i = !(c >= 5 && c <= 8);
         #1;
         obs = {vrf_ren_o, wb_valid_o, done_o, alu_stall_o};
         exp = {(c <= 4) || (c >= 9 && c <= 12), (c >= 4 && c <= 15), (c == 16), (c >= 5 && c <= 8)};
         total_cnt++;
         if (obs !== exp) $display("FAIL stall_ctrl c=%0d got %b want %b", c, obs, exp);
         else pass_cnt++;
         if (c <= 12) begin
            ea = (c <= 4) ? c - 1 : ((c <= 8) ? 4 : c - 5);
            total_cnt++;
            if (vrf_raddr_o !== 9'(ea)) $display("FAIL stall_raddr c=%0d got %0d want %0d", c, vrf_raddr_o, ea);
            else pass_cnt++;
         end
         if (exp[2]) begin
            ea = (c == 4) ? 0 : ((c <= 9) ? 1 : c - 8);
            total_cnt++;
            if ({wb_addr_o, wb_lane_en_o} !== {9'(ea), 4'b1111})
               $display("FAIL stall_wb c=%0d got addr=%0d mask=%b want addr=%0d mask=1111", c, wb_addr_o, wb_lane_en_o, ea);
            else pass_cnt++;
         end
         @(posedge clk);
         #1;
      end
      wb_ready_i = 1'b1;
   endtask

   task automatic test_vl_zero();
      logic [4:0] obs, exp;
      send(7'h01, 12'd0, 1'b0);
      for (int c = 1; c <= 3; c++) begin
         obs = {instr_ready_o, busy_o, done_o, vrf_ren_o, wb_valid_o};
         exp = (c == 1) ? 5'b01100 : 5'b10000;
         total_cnt++;
         if (obs !== exp) $display("FAIL vl0 c=%0d got %b want %b", c, obs, exp);
         else pass_cnt++;
         step();
      end
   endtask

   task automatic test_reset_abort();
      logic [4:0] obs;
      send(7'h44, 12'd32, 1'b0);
      step();
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      obs = {instr_ready_o, busy_o, done_o, vrf_ren_o, wb_valid_o};
      total_cnt++;
      if (obs !== 5'b10000) $display("FAIL abort_state got %b want 10000", obs);
      else pass_cnt++;
      for (int c = 0; c < 8; c++) begin
         step();
         obs = {instr_ready_o, busy_o, done_o, vrf_ren_o, wb_valid_o};
         total_cnt++;
         if (obs !== 5'b10000) $display("FAIL abort_quiet c=%0d got %b want 10000", c, obs);
         else pass_cnt++;
      end
   endtask

   // A mul32 instruction followed straight away by a normal one: mode and masks must switch.
   task automatic test_back_to_back();
      logic [2:0] obs, exp;
      send(7'h11, 12'd1, 1'b1);
      for (int c = 1; c <= 7; c++) begin
         obs = {vrf_ren_o, wb_valid_o, done_o};
         exp = {(c == 1), (c == 6), (c == 7)};
         total_cnt++;
         if (obs !== exp) $display("FAIL b2b_first c=%0d got %b want %b", c, obs, exp);
         else pass_cnt++;
         step();
      end
      total_cnt++;
      if (instr_ready_o !== 1'b1) $display("FAIL b2b_ready got %b want 1", instr_ready_o);
      else pass_cnt++;
      send(7'h22, 12'd5, 1'b0);
      total_cnt++;
      if (alu_en_32bit_mul_o !== 1'b0) $display("FAIL b2b_mode got %b want 0", alu_en_32bit_mul_o);
      else pass_cnt++;
      for (int c = 1; c <= 7; c++) begin
         obs = {vrf_ren_o, wb_valid_o, done_o};
         exp = {(c <= 2), (c == 4 || c == 5), (c == 6)};
         total_cnt++;
         if (obs !== exp) $display("FAIL b2b_second c=%0d got %b want %b", c, obs, exp);
         else pass_cnt++;
         if (exp[1]) begin
            total_cnt++;
            if ({wb_addr_o, wb_lane_en_o} !== {9'(c - 4), (c == 4) ? 4'b1111 : 4'b0001})
               $display("FAIL b2b_wb c=%0d got addr=%0d mask=%b", c, wb_addr_o, wb_lane_en_o);
            else pass_cnt++;
         end
         step();
      end
   endtask

   initial begin
      rst            = 1'b1;
      instr_valid_i  = 1'b0;
      instr_opmode_i = '0;
      instr_vl_i     = '0;
      instr_mul32_i  = 1'b0;
      wb_ready_i     = 1'b1;
      step();
      step();
      test_reset();
      rst = 1'b0;
      step();
      test_basic();
      test_partial_mask();
      test_mul32();
      test_stall();
      test_vl_zero();
      test_reset_abort();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout got running want finished");
      $fatal(1, "watchdog");
   end

endmodule
